// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store controller:
// funct3 encodings, FSM/requester enums and access-decode helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {REQ_CORE, REQ_DBG} req_t;

  // Illegal funct3 or an offset that does not match the access size.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (f3)
        F3_B:    bad = 1'b0;
        F3_H:    bad = off[0];
        F3_W:    bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: bad = 1'b0;
        F3_H, F3_HU: bad = off[0];
        F3_W:        bad = (off != 2'b00);
        default:     bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] lanes;
    case (f3)
      F3_B:    lanes = 4'b0001 << off;
      F3_H:    lanes = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load data lane select and sign/zero extension of the returned memory word.
module dmem_load_ext import dmem_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = DATA_W'(lane_b);
      F3_BU:   data = DATA_W'($unsigned(lane_b));
      F3_H:    data = DATA_W'(lane_h);
      F3_HU:   data = DATA_W'($unsigned(lane_h));
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: round-robin arbitration between core and debug ports,
// byte-lane store formatting, load extension and access error flagging.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_t            state;
  req_t              last_grant;
  req_t              rd_src_p1;
  logic [2:0]        f3_p1;
  logic [1:0]        off_p1;
  logic              in_idle;
  logic              core_wins;
  logic              core_sel;
  logic              dbg_sel;
  logic              core_bad;
  logic              rd_live;
  logic [DATA_W-1:0] ext_data;
  logic              dbg_addr_unused;

  assign dbg_addr_unused = ^dbg_addr[1:0];

  // Stage p0: arbitration and memory request, all combinational from IDLE.
  // Reset masks every output so a pending read or new grant never leaks out.
  assign in_idle   = !reset && (state == IDLE);
  assign core_wins = core_req && (!dbg_req || (last_grant == REQ_DBG));
  assign core_sel  = in_idle && core_wins;
  assign dbg_sel   = in_idle && dbg_req && !core_wins;
  assign core_bad  = access_err(core_we, core_funct3, core_addr[1:0]);

  assign core_gnt = core_sel;
  assign dbg_gnt  = dbg_sel;
  assign core_err = core_sel && core_bad;

  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 4'b0000;
    mem_wdata = '0;
    if (core_sel && !core_bad) begin
      mem_addr = {core_addr[DM_ADDRESS-1:2], 2'b00};
      if (core_we) begin
        mem_we = store_lanes(core_funct3, core_addr[1:0]);
        case (core_funct3)
          F3_B:    mem_wdata = {4{core_wdata[7:0]}};
          F3_H:    mem_wdata = {2{core_wdata[15:0]}};
          default: mem_wdata = core_wdata;
        endcase
      end else begin
        mem_re = 1'b1;
      end
    end else if (dbg_sel) begin
      mem_addr = {dbg_addr[DM_ADDRESS-1:2], 2'b00};
      if (dbg_we) begin
        mem_we    = 4'b1111;
        mem_wdata = dbg_wdata;
      end else begin
        mem_re = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_DBG;
      rd_src_p1  <= REQ_CORE;
    end else begin
      case (state)
        IDLE: begin
          if (core_sel) begin
            last_grant <= REQ_CORE;
            if (!core_bad && !core_we) begin
              state     <= RD_WAIT;
              rd_src_p1 <= REQ_CORE;
            end
          end else if (dbg_sel) begin
            last_grant <= REQ_DBG;
            if (!dbg_we) begin
              state     <= RD_WAIT;
              rd_src_p1 <= REQ_DBG;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane selection for the returning read; debug reads are forced to whole words.
  always_ff @(posedge clk) begin
    if (core_sel) begin
      f3_p1  <= core_funct3;
      off_p1 <= core_addr[1:0];
    end else if (dbg_sel) begin
      f3_p1  <= F3_W;
      off_p1 <= 2'b00;
    end
  end

  // Stage p1: read data return and extension.
  dmem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .funct3 (f3_p1),
    .offset (off_p1),
    .word   (mem_rdata),
    .data   (ext_data)
  );

  assign rd_live     = !reset && (state == RD_WAIT);
  assign core_rvalid = rd_live && (rd_src_p1 == REQ_CORE);
  assign dbg_rvalid  = rd_live && (rd_src_p1 == REQ_DBG);
  assign core_rdata  = core_rvalid ? ext_data : '0;
  assign dbg_rdata   = dbg_rvalid ? ext_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed requests push expected grants, writes
// and read returns into queues that a negedge monitor drains against the DUT.
module tb_dmem_ctrl;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  typedef struct { logic cg; logic dg; logic err; logic re; logic [8:0] addr; int cyc; } gnt_t;
  typedef struct { logic [8:0] addr; logic [3:0] we; logic [31:0] wdata; int cyc; } wr_t;
  typedef struct { logic [31:0] data; int cyc; } rd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [2:0]  core_funct3;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:127];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  gnt_t gnt_q[$];
  wr_t  wr_q[$];
  rd_t  crd_q[$];
  rd_t  drd_q[$];
  gnt_t mg;
  wr_t  mw;
  rd_t  mr;

  dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-wide memory with byte lanes and one-cycle read latency.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: every DUT-presented event must match the head of its queue.
  always @(negedge clk) begin
    if (mem_re || mem_we != 4'b0000)
      chk("re_we_exclusive", 32'(mem_re && (mem_we != 4'b0000)), 32'd0);
    if (core_gnt || dbg_gnt) begin
      if (gnt_q.size() == 0) unexpected("grant");
      else begin
        mg = gnt_q.pop_front();
        chk("gnt_flags", {28'd0, core_gnt, dbg_gnt, core_err, mem_re}, {28'd0, mg.cg, mg.dg, mg.err, mg.re});
        chk("gnt_cycle", cyc, mg.cyc);
        if (mg.re) chk("rd_addr", 32'(mem_addr), 32'(mg.addr));
      end
    end else if (mem_re) unexpected("mem_re_no_gnt");
    if (mem_we != 4'b0000) begin
      if (wr_q.size() == 0) unexpected("write");
      else begin
        mw = wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mw.addr));
        chk("wr_lanes", 32'(mem_we), 32'(mw.we));
        chk("wr_data", mem_wdata, mw.wdata);
        chk("wr_cycle", cyc, mw.cyc);
      end
    end
    if (core_rvalid) begin
      if (crd_q.size() == 0) unexpected("core_rvalid");
      else begin
        mr = crd_q.pop_front();
        chk("core_rdata", core_rdata, mr.data);
        chk("core_rcycle", cyc, mr.cyc);
      end
    end
    if (dbg_rvalid) begin
      if (drd_q.size() == 0) unexpected("dbg_rvalid");
      else begin
        mr = drd_q.pop_front();
        chk("dbg_rdata", dbg_rdata, mr.data);
        chk("dbg_rcycle", cyc, mr.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input logic cg, input logic dg, input logic err, input logic re,
                         input logic [8:0] addr, input int c);
    gnt_t g;
    g.cg = cg; g.dg = dg; g.err = err; g.re = re; g.addr = addr; g.cyc = c;
    gnt_q.push_back(g);
  endtask

  task automatic exp_wr(input logic [8:0] addr, input logic [3:0] we, input logic [31:0] wd, input int c);
    wr_t w;
    w.addr = addr; w.we = we; w.wdata = wd; w.cyc = c;
    wr_q.push_back(w);
  endtask

  task automatic exp_rd(input logic is_dbg, input logic [31:0] d, input int c);
    rd_t r;
    r.data = d; r.cyc = c;
    if (is_dbg) drd_q.push_back(r);
    else crd_q.push_back(r);
  endtask

  task automatic core_set(input logic req, input logic we, input logic [2:0] f3,
                          input logic [8:0] addr, input logic [31:0] wd);
    core_req = req; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wd;
  endtask

  task automatic dbg_set(input logic req, input logic we, input logic [8:0] addr, input logic [31:0] wd);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
  endtask

  task automatic core_store(input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wd,
                            input logic [8:0] maddr, input logic [3:0] lanes, input logic [31:0] mwd);
    core_set(1'b1, 1'b1, f3, addr, wd);
    exp_gnt(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, cyc);
    exp_wr(maddr, lanes, mwd, cyc);
    step();
  endtask

  task automatic core_load(input logic [2:0] f3, input logic [8:0] addr,
                           input logic [8:0] maddr, input logic [31:0] data);
    core_set(1'b1, 1'b0, f3, addr, 32'h0);
    exp_gnt(1'b1, 1'b0, 1'b0, 1'b1, maddr, cyc);
    exp_rd(1'b0, data, cyc + 1);
    step();
    core_req = 1'b0;
    step();
  endtask

  task automatic core_bad(input logic we, input logic [2:0] f3, input logic [8:0] addr);
    core_set(1'b1, we, f3, addr, 32'h5555_AAAA);
    exp_gnt(1'b1, 1'b0, 1'b1, 1'b0, 9'h0, cyc);
    step();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {26'd0, core_gnt, dbg_gnt, core_err, core_rvalid, dbg_rvalid, mem_re}, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_core_rdata"}, core_rdata, 32'd0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  int c0;

  initial begin
    reset = 1'b1;
    core_set(1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
    dbg_set(1'b0, 1'b0, 9'h0, 32'h0);
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    step();

    // Debug word writes (low address bits ignored) and read-back.
    dbg_set(1'b1, 1'b1, 9'h010, 32'h80FF_7F01);
    exp_gnt(1'b0, 1'b1, 1'b0, 1'b0, 9'h0, cyc);
    exp_wr(9'h010, 4'b1111, 32'h80FF_7F01, cyc);
    step();
    dbg_set(1'b1, 1'b1, 9'h00F, 32'hDEAD_BEEF);
    exp_gnt(1'b0, 1'b1, 1'b0, 1'b0, 9'h0, cyc);
    exp_wr(9'h00C, 4'b1111, 32'hDEAD_BEEF, cyc);
    step();
    dbg_set(1'b1, 1'b0, 9'h00C, 32'h0);
    exp_gnt(1'b0, 1'b1, 1'b0, 1'b1, 9'h00C, cyc);
    exp_rd(1'b1, 32'hDEAD_BEEF, cyc + 1);
    step();
    dbg_req = 1'b0;
    step();

    // Back-to-back core stores, one per cycle.
    core_store(LB, 9'h006, 32'h0000_00AB, 9'h004, 4'b0100, 32'hABAB_ABAB);
    core_store(LH, 9'h02A, 32'hFFFF_1234, 9'h028, 4'b1100, 32'h1234_1234);
    core_store(LW, 9'h030, 32'h1122_3344, 9'h030, 4'b1111, 32'h1122_3344);
    core_req = 1'b0;
    step();

    // Loads with extension from word 0x80FF7F01 at 0x010.
    core_load(LB,  9'h013, 9'h010, 32'hFFFF_FF80);
    core_load(LBU, 9'h013, 9'h010, 32'h0000_0080);
    core_load(LH,  9'h012, 9'h010, 32'hFFFF_80FF);
    core_load(LHU, 9'h010, 9'h010, 32'h0000_7F01);
    core_load(LB,  9'h010, 9'h010, 32'h0000_0001);
    core_load(LH,  9'h010, 9'h010, 32'h0000_7F01);
    core_load(LW,  9'h010, 9'h010, 32'h80FF_7F01);
    core_load(LHU, 9'h02A, 9'h028, 32'h0000_1234);
    core_load(LB,  9'h031, 9'h030, 32'h0000_0033);
    core_load(LBU, 9'h006, 9'h004, 32'h0000_00AB);

    // Errors: granted, flagged, no memory access, no read wait.
    core_bad(1'b0, LW, 9'h022);
    core_bad(1'b1, LH, 9'h021);
    core_bad(1'b0, 3'b011, 9'h000);
    core_bad(1'b0, 3'b110, 9'h004);
    core_bad(1'b1, 3'b100, 9'h008);
    core_bad(1'b0, LHU, 9'h013);
    core_req = 1'b0;
    step();

    // Both requesters hold loads from reset: core, dbg, core.
    reset = 1'b1;
    step();
    reset = 1'b0;
    core_set(1'b1, 1'b0, LW, 9'h010, 32'h0);
    dbg_set(1'b1, 1'b0, 9'h00C, 32'h0);
    c0 = cyc;
    exp_gnt(1'b1, 1'b0, 1'b0, 1'b1, 9'h010, c0);
    exp_rd(1'b0, 32'h80FF_7F01, c0 + 1);
    exp_gnt(1'b0, 1'b1, 1'b0, 1'b1, 9'h00C, c0 + 2);
    exp_rd(1'b1, 32'hDEAD_BEEF, c0 + 3);
    exp_gnt(1'b1, 1'b0, 1'b0, 1'b1, 9'h010, c0 + 4);
    exp_rd(1'b0, 32'h80FF_7F01, c0 + 5);
    repeat (6) step();
    core_req = 1'b0;
    dbg_req = 1'b0;
    step();

    // Reset while a load is in flight drops the return.
    core_set(1'b1, 1'b0, LW, 9'h010, 32'h0);
    exp_gnt(1'b1, 1'b0, 1'b0, 1'b1, 9'h010, cyc);
    step();
    core_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");
    step();

    // After that reset the core wins a tie again.
    core_set(1'b1, 1'b1, LW, 9'h040, 32'hCAFE_F00D);
    dbg_set(1'b1, 1'b1, 9'h044, 32'h0BAD_F00D);
    exp_gnt(1'b1, 1'b0, 1'b0, 1'b0, 9'h0, cyc);
    exp_wr(9'h040, 4'b1111, 32'hCAFE_F00D, cyc);
    exp_gnt(1'b0, 1'b1, 1'b0, 1'b0, 9'h0, cyc + 1);
    exp_wr(9'h044, 4'b1111, 32'h0BAD_F00D, cyc + 1);
    step();
    core_req = 1'b0;
    step();
    dbg_req = 1'b0;
    repeat (2) step();

    chk("gnt_q_drained", gnt_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("crd_q_drained", crd_q.size(), 32'd0);
    chk("drd_q_drained", drd_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Load/store controller that sits between the pipeline's MEM stage, a debug/DMA word port and the data memory.
- Arbitrates the single memory port between the two requesters.
- Converts RISC-V load/store funct3 requests into word-aligned accesses with byte-lane write enables.
- Sign- or zero-extends returned load data.
- Flags misaligned or illegal accesses.

Parameters:
DM_ADDRESS, 9, byte-address width of data memory
DATA_W, 32, data width (only 32 supported)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
core_req  in  1  core access request
core_we  in  1  1=store, 0=load
core_funct3  in  3  instruction bits 14:12
core_addr  in  DM_ADDRESS  byte address
core_wdata  in  DATA_W  store data (low bits used for SB/SH)
core_gnt  out  1  request accepted this cycle
core_rvalid  out  1  load data valid
core_rdata  out  DATA_W  extended load data
core_err  out  1  misaligned/illegal access, pulses at grant
dbg_req  in  1  debug word-access request
dbg_we  in  1  1=write word
dbg_addr  in  DM_ADDRESS  byte address, bits 1:0 ignored
dbg_wdata  in  DATA_W  write data
dbg_gnt  out  1  request accepted
dbg_rvalid  out  1  read data valid
dbg_rdata  out  DATA_W  read word
mem_addr  out  DM_ADDRESS  word-aligned address, bits 1:0 = 0
mem_re  out  1  read strobe
mem_we  out  4  byte-lane write enables
mem_wdata  out  DATA_W  lane-positioned write data
mem_rdata  in  DATA_W  read data, valid the cycle after mem_re

Behaviour:
Clock and reset:
- Single clock clk; reset is synchronous and active-high.
- After reset: state=IDLE, last_grant=DBG, and all outputs 0 (gnt, rvalid, err, mem_re, mem_we, rdata).

FSM states: IDLE and RD_WAIT.

IDLE:
- Grants are issued combinationally from IDLE only.
- If only one requester is active, it is granted. If both are active, the requester that is not last_grant wins (round-robin). Update last_grant on every grant.
- Granted store: drive mem_we, mem_addr and mem_wdata in the same cycle. The write completes; stay in IDLE.
- Granted load: drive mem_re and mem_addr. Register requester id, funct3 and addr[1:0]; go to RD_WAIT.

RD_WAIT:
- No grants in this state.
- Extend mem_rdata and drive the requester's rvalid=1 with rdata, both combinational.
- Return to IDLE.
- Read throughput: 1 read per 2 cycles. Write throughput: 1 write per cycle.

Core store lanes:
- SB (000): mem_we = 0001 shifted left by addr[1:0]; mem_wdata = byte replicated x4.
- SH (001): mem_we = 0011 if addr[1]=0, else 1100; mem_wdata = halfword replicated x2.
- SW (010): mem_we = 1111.

Core loads:
- LB (000) / LBU (100): select byte at addr[1:0]; LB sign-extends, LBU zero-extends.
- LH (001) / LHU (101): select halfword at addr[1]; LH sign-extends, LHU zero-extends.
- LW (010): whole word.

Error handling:
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 greater than 010.
- On error, assert core_gnt=1 and core_err=1 for one cycle.
- On error: no mem_re/mem_we, no rvalid, state stays IDLE. The grant still counts for round-robin.

Debug port: always word access; addr[1:0] forced to 0; never raises an error.

Boundary conditions:
- A request held through RD_WAIT is granted in the following IDLE cycle.
- Reset during RD_WAIT: go to IDLE with no rvalid. The pending load is dropped.
- A request deasserted before grant is simply not served; no request queueing.
- mem_we and mem_re are never asserted together.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: IDLE, RD_WAIT.
  - requester enum: REQ_CORE, REQ_DBG.
- One sub-module, dmem_load_ext: combinational lane select plus sign/zero extension (funct3, offset, word → DATA_W).

Test Plan:
- Core SB addr=0x006, wdata=0x000000AB → mem_addr=0x004, mem_we=0100, mem_wdata=0xABABABAB, core_gnt=1, state stays IDLE.
- Memory word 0x80FF7F01 at 0x010. Core LB at 0x013 → core_rvalid the next cycle, rdata=0xFFFFFF80. LBU at 0x013 → 0x00000080. LH at 0x012 → 0xFFFF80FF. LHU at 0x010 → 0x00007F01.
- Core LW at 0x022 → core_gnt=1, core_err=1, no mem_re/mem_we, no rvalid. SH at 0x021 → same result.
- core_req and dbg_req held continuously with loads, out of reset → grants go core, dbg, core on cycles 0, 2 and 4. rvalid appears on cycles 1, 3 and 5 on the matching port.
- Core LW issued, then reset asserted in RD_WAIT → no core_rvalid; the next cycle is IDLE with all outputs 0.
- dbg write 0xDEADBEEF at 0x00F → mem_addr=0x00C, mem_we=1111. A following dbg read of 0x00C returns dbg_rdata=0xDEADBEEF.
